// File: rtl/uart_pkg.sv
// Shared UART definitions for the MMIO transmitter and the UART programmer receiver.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DATA_BITS     = 8;
  localparam int STOP_BITS     = 1;
  localparam int MMIO_BYTE_LSB = 0;
endpackage

// File: rtl/uart_mmio_tx_if.sv
// Core MMIO store path into the UART transmit data register.
interface uart_mmio_tx_if;
  logic        mmio_wea;
  logic [31:0] mmio_dat;
  logic        mmio_read;
  logic        tx_hold;

  modport master (output mmio_wea, mmio_dat, input mmio_read, tx_hold);
  modport slave  (input mmio_wea, mmio_dat, output mmio_read, tx_hold);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; push when full and pop when empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/uart_mmio_tx.sv
// MMIO-fed 8N1 UART transmitter: byte FIFO plus serialiser FSM.
module uart_mmio_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          Rst,
  uart_mmio_tx_if.slave                 mmio,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_irq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  tx_state_t            state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 irq_q, irq_d;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 baud_last;

  assign fifo_push      = mmio.mmio_wea & ~fifo_full;
  assign mmio.tx_hold   = mmio.mmio_wea & fifo_full;
  assign mmio.mmio_read = ~fifo_full;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk     (clk),
    .rst_n   (Rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (mmio.mmio_dat[MMIO_BYTE_LSB +: DATA_BITS]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign baud_last = (baud_q == 16'(BAUD_DIV - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    irq_d    = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else baud_d = baud_q + 16'd1;
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = STOP;
          end else bit_d = bit_q + 3'd1;
        end else baud_d = baud_q + 16'd1;
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Back-to-back frames: pop straight into the next start bit.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
          end else begin
            state_d = IDLE;
            irq_d   = 1'b1;
          end
        end else baud_d = baud_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the current state one cycle later, so every bit is BAUD_DIV long.
  always_comb begin
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
    end
  end

  assign tx      = tx_q;
  assign tx_irq  = irq_q;
  assign tx_busy = (state_q != IDLE) | (fifo_count != '0);
endmodule
